// File: rtl/i2c_master_address_uc.sv
// Single-master I2C address/data engine: START, LSB-first address + R/W, positive-ack
// handshakes, byte streaming with write-side clock stretching, and STOP.
module i2c_master_address_uc #(
  parameter int ADDRESSLENGTH = 7,
  parameter int CLKDIV        = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     Start,
  input  logic [ADDRESSLENGTH-1:0] Addr,
  input  logic                     RW,
  input  logic [7:0]               NBytes,
  input  logic [7:0]               TxData,
  input  logic                     TxValid,
  output logic                     TxReady,
  output logic [7:0]               RxData,
  output logic                     RxValid,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Nack,
  output logic                     SCL,
  input  logic                     SDA_in,
  output logic                     SDA_oe
);

  localparam int DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int MAXB = (ADDRESSLENGTH > 8) ? ADDRESSLENGTH : 8;
  localparam int BITW = $clog2(MAXB);
  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLKDIV - 1);
  localparam logic [BITW-1:0] ADDR_LAST = BITW'(ADDRESSLENGTH - 1);
  localparam logic [BITW-1:0] BYTE_LAST = BITW'(7);

  typedef enum logic [2:0] {IDLE, START, ADDR, RWBIT, AACK, DATA, DACK, STOP} state_t;

  state_t                   state_q, state_d;
  logic [DIVW-1:0]          div_q, div_d;
  logic [1:0]               phase_q, phase_d;
  logic [BITW-1:0]          bit_q, bit_d;
  logic [ADDRESSLENGTH-1:0] addr_sh_q, addr_sh_d;
  logic                     rw_q, rw_d;
  logic [7:0]               nbytes_q, nbytes_d;
  logic [7:0]               byte_cnt_q, byte_cnt_d;
  logic [7:0]               tx_sh_q, tx_sh_d;
  logic [7:0]               rx_sh_q, rx_sh_d;
  logic [7:0]               rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     done_q, done_d;
  logic                     nack_q, nack_d;
  logic                     ack_q, ack_d;

  logic q_end, sample_pt, cell_end, cell_high, tx_slot, tx_ready;

  assign q_end     = (div_q == DIV_LAST);
  assign sample_pt = q_end && (phase_q == 2'd1);
  assign cell_end  = q_end && (phase_q == 2'd3);
  assign cell_high = (phase_q == 2'd1) || (phase_q == 2'd2);
  // The write byte is handed over only at the very first cycle of bit 0; without data we park here with SCL low.
  assign tx_slot   = (state_q == DATA) && !rw_q && (bit_q == '0) && (phase_q == 2'd0) && (div_q == '0);
  assign tx_ready  = tx_slot && TxValid;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    addr_sh_d  = addr_sh_q;
    rw_d       = rw_q;
    nbytes_d   = nbytes_q;
    byte_cnt_d = byte_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    nack_d     = nack_q;
    ack_d      = ack_q;

    if (state_q != IDLE && !(tx_slot && !TxValid)) begin
      div_d = q_end ? '0 : div_q + 1'b1;
      if (q_end) phase_d = phase_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = START;
          addr_sh_d = Addr;
          rw_d      = RW;
          nbytes_d  = NBytes;
          nack_d    = 1'b0;
          div_d     = '0;
          phase_d   = 2'd0;
          bit_d     = '0;
        end
      end
      START: begin
        if (q_end && phase_q == 2'd1) begin
          state_d = ADDR;
          phase_d = 2'd0;
        end
      end
      ADDR: begin
        if (cell_end) begin
          addr_sh_d = addr_sh_q >> 1;
          if (bit_q == ADDR_LAST) begin
            bit_d   = '0;
            state_d = RWBIT;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      RWBIT: begin
        if (cell_end) state_d = AACK;
      end
      AACK: begin
        if (sample_pt) begin
          ack_d = SDA_in;
          if (!SDA_in) nack_d = 1'b1;
        end
        if (cell_end) begin
          if (!ack_q || nbytes_q == 8'd0) begin
            state_d = STOP;
          end else begin
            state_d    = DATA;
            byte_cnt_d = nbytes_q;
          end
        end
      end
      DATA: begin
        if (tx_ready) tx_sh_d = TxData;
        if (rw_q && sample_pt) begin
          rx_sh_d = {SDA_in, rx_sh_q[7:1]};
          if (bit_q == BYTE_LAST) begin
            rx_data_d  = {SDA_in, rx_sh_q[7:1]};
            rx_valid_d = 1'b1;
          end
        end
        if (cell_end) begin
          tx_sh_d = tx_sh_q >> 1;
          if (bit_q == BYTE_LAST) begin
            bit_d   = '0;
            state_d = DACK;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      DACK: begin
        if (!rw_q && sample_pt) begin
          ack_d = SDA_in;
          if (!SDA_in) nack_d = 1'b1;
        end
        if (cell_end) begin
          if (byte_cnt_q != 8'd0) byte_cnt_d = byte_cnt_q - 8'd1;
          if ((!rw_q && !ack_q) || byte_cnt_q <= 8'd1) state_d = STOP;
          else                                         state_d = DATA;
        end
      end
      STOP: begin
        if (q_end && phase_q == 2'd2) begin
          state_d = IDLE;
          done_d  = 1'b1;
          div_d   = '0;
          phase_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus pins decode straight from state so reset releases the bus in the same cycle.
  always_comb begin
    SCL    = 1'b1;
    SDA_oe = 1'b0;
    case (state_q)
      START: begin
        SCL    = (phase_q == 2'd0);
        SDA_oe = 1'b1;
      end
      ADDR: begin
        SCL    = cell_high;
        SDA_oe = ~addr_sh_q[0];
      end
      RWBIT: begin
        SCL    = cell_high;
        SDA_oe = ~rw_q;
      end
      AACK: SCL = cell_high;
      DATA: begin
        SCL = cell_high;
        if (!rw_q) SDA_oe = tx_slot ? (TxValid & ~TxData[0]) : ~tx_sh_q[0];
      end
      DACK: begin
        SCL = cell_high;
        if (rw_q) SDA_oe = (byte_cnt_q <= 8'd1);
      end
      STOP: begin
        SCL    = (phase_q != 2'd0);
        SDA_oe = (phase_q < 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      div_q      <= '0;
      phase_q    <= 2'd0;
      bit_q      <= '0;
      addr_sh_q  <= '0;
      rw_q       <= 1'b0;
      nbytes_q   <= 8'd0;
      byte_cnt_q <= 8'd0;
      tx_sh_q    <= 8'd0;
      rx_sh_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      addr_sh_q  <= addr_sh_d;
      rw_q       <= rw_d;
      nbytes_q   <= nbytes_d;
      byte_cnt_q <= byte_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      ack_q      <= ack_d;
    end
  end

  assign TxReady = tx_ready;
  assign RxData  = rx_data_q;
  assign RxValid = rx_valid_q;
  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign Nack    = nack_q;

endmodule

// File: tb/tb_i2c_master_address_uc.sv
// Directed bench for i2c_master_address_uc with a bit-cell slave model and bus monitor.
module tb_i2c_master_address_uc;

  localparam int AL = 7;
  localparam int CD = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          Start = 1'b0;
  logic [AL-1:0] Addr = '0;
  logic          RW = 1'b0;
  logic [7:0]    NBytes = 8'd0;
  logic [7:0]    TxData = 8'd0;
  logic          TxValid = 1'b0;
  logic          TxReady, RxValid, Busy, Done, Nack, SCL, SDA_oe, SDA_in;
  logic [7:0]    RxData;

  i2c_master_address_uc #(.ADDRESSLENGTH(AL), .CLKDIV(CD)) dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Addr(Addr), .RW(RW), .NBytes(NBytes),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady), .RxData(RxData),
    .RxValid(RxValid), .Busy(Busy), .Done(Done), .Nack(Nack), .SCL(SCL),
    .SDA_in(SDA_in), .SDA_oe(SDA_oe)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int rise_total = 0, tx_ready_total = 0, rx_valid_total = 0, done_total = 0;
  int start_total = 0, stop_total = 0, overlap_total = 0;
  int rise_base = 0, tx_base = 0, rx_base = 0, done_base = 0, start_base = 0, stop_base = 0;

  logic [63:0] resp = '1;
  logic [63:0] cap = '0;
  logic [7:0]  rx_log [0:15];
  logic        scl_prev = 1'b1;
  logic        line_prev = 1'b1;
  logic [5:0]  cell_idx;
  logic        slave_bit;

  // The slave answers per bit cell: resp[k] is what it leaves on the line during cell k after START.
  assign cell_idx  = 6'(rise_total - rise_base - 1);
  assign slave_bit = (rise_total > rise_base) ? resp[cell_idx] : 1'b1;
  assign SDA_in    = SDA_oe ? 1'b0 : slave_bit;

  // Bus monitor: counts SCL rises, records the wired-AND line per cell, and detects START/STOP and pulses.
  always @(negedge CLK) begin : monitor
    int         rnext;
    logic [5:0] idx;
    logic       line;
    rnext = rise_total + ((SCL && !scl_prev) ? 1 : 0);
    idx   = 6'(rnext - rise_base - 1);
    line  = SDA_oe ? 1'b0 : ((rnext > rise_base) ? resp[idx] : 1'b1);
    rise_total <= rnext;
    if (SCL) cap[idx] <= line;
    if (SCL && scl_prev && line_prev && !line) start_total <= start_total + 1;
    if (SCL && scl_prev && !line_prev && line) stop_total <= stop_total + 1;
    if (TxReady) tx_ready_total <= tx_ready_total + 1;
    if (RxValid) begin
      rx_log[4'(rx_valid_total)] <= RxData;
      rx_valid_total <= rx_valid_total + 1;
    end
    if (Done) done_total <= done_total + 1;
    if ((int'(TxReady) + int'(RxValid) + int'(Done)) > 1) overlap_total <= overlap_total + 1;
    scl_prev  <= SCL;
    line_prev <= line;
  end

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [AL-1:0] a, input logic rw, input logic [7:0] nb);
    @(posedge CLK); #1;
    rise_base  = rise_total;
    tx_base    = tx_ready_total;
    rx_base    = rx_valid_total;
    done_base  = done_total;
    start_base = start_total;
    stop_base  = stop_total;
    Addr   = a;
    RW     = rw;
    NBytes = nb;
    Start  = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (done_total == done_base && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    checkOutput({tag, "_done_seen"}, 32'(n < 2000), 32'd1);
    checkOutput({tag, "_done_width"}, 32'(Done), 32'd0);
    checkOutput({tag, "_busy_after"}, 32'(Busy), 32'd0);
  endtask

  task automatic waitRise(input string tag, input int target);
    int n = 0;
    while ((rise_total - rise_base) < target && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    checkOutput({tag, "_rise_timeout"}, 32'(n < 2000), 32'd1);
  endtask

  function automatic logic [7:0] capBits(input int first, input int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[3'(i)] = cap[6'(first + i)];
    return r;
  endfunction

  task automatic loadSlaveByte(input int first, input logic [7:0] b);
    for (int i = 0; i < 8; i++) resp[6'(first + i)] = b[3'(i)];
  endtask

  // Directed sequence: reset, write, read, address NACK, stretch, busy-Start/NBytes=0, mid-byte reset.
  initial begin : stimulus
    int scl_high;
    int n;

    repeat (2) @(negedge CLK);
    checkOutput("rst_scl", 32'(SCL), 32'd1);
    checkOutput("rst_sda_oe", 32'(SDA_oe), 32'd0);
    checkOutput("rst_busy", 32'(Busy), 32'd0);
    checkOutput("rst_done", 32'(Done), 32'd0);
    checkOutput("rst_nack", 32'(Nack), 32'd0);
    checkOutput("rst_txready", 32'(TxReady), 32'd0);
    checkOutput("rst_rxvalid", 32'(RxValid), 32'd0);
    checkOutput("rst_rxdata", 32'(RxData), 32'h00);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    $display("[TB] write 0x2A / 0xA5");
    resp = '1;
    TxData = 8'hA5;
    TxValid = 1'b1;
    applyStimulus(7'h2A, 1'b0, 8'd1);
    waitDone("wr");
    checkOutput("wr_addr_bits", 32'(capBits(0, 7)), 32'h2A);
    checkOutput("wr_rw_bit", 32'(cap[7]), 32'd0);
    checkOutput("wr_aack", 32'(cap[8]), 32'd1);
    checkOutput("wr_data_bits", 32'(capBits(9, 8)), 32'hA5);
    checkOutput("wr_txready_cnt", 32'(tx_ready_total - tx_base), 32'd1);
    checkOutput("wr_rxvalid_cnt", 32'(rx_valid_total - rx_base), 32'd0);
    checkOutput("wr_start_cnt", 32'(start_total - start_base), 32'd1);
    checkOutput("wr_stop_cnt", 32'(stop_total - stop_base), 32'd1);
    checkOutput("wr_nack", 32'(Nack), 32'd0);
    TxValid = 1'b0;

    $display("[TB] read 0x11, two bytes");
    resp = '1;
    loadSlaveByte(9, 8'h3C);
    loadSlaveByte(18, 8'hC3);
    applyStimulus(7'h11, 1'b1, 8'd2);
    waitDone("rd");
    checkOutput("rd_addr_bits", 32'(capBits(0, 7)), 32'h11);
    checkOutput("rd_rw_bit", 32'(cap[7]), 32'd1);
    checkOutput("rd_rxvalid_cnt", 32'(rx_valid_total - rx_base), 32'd2);
    checkOutput("rd_byte0", 32'(rx_log[4'(rx_base)]), 32'h3C);
    checkOutput("rd_byte1", 32'(rx_log[4'(rx_base + 1)]), 32'hC3);
    checkOutput("rd_mack_first", 32'(cap[17]), 32'd1);
    checkOutput("rd_mack_last", 32'(cap[26]), 32'd0);
    checkOutput("rd_rxdata", 32'(RxData), 32'hC3);
    checkOutput("rd_txready_cnt", 32'(tx_ready_total - tx_base), 32'd0);
    checkOutput("rd_stop_cnt", 32'(stop_total - stop_base), 32'd1);

    $display("[TB] address NACK");
    resp = '1;
    resp[8] = 1'b0;
    TxData = 8'h77;
    TxValid = 1'b1;
    applyStimulus(7'h55, 1'b0, 8'd1);
    waitDone("nk");
    checkOutput("nk_nack", 32'(Nack), 32'd1);
    checkOutput("nk_txready_cnt", 32'(tx_ready_total - tx_base), 32'd0);
    checkOutput("nk_cells", 32'(rise_total - rise_base), 32'd10);
    checkOutput("nk_stop_cnt", 32'(stop_total - stop_base), 32'd1);
    TxValid = 1'b0;

    $display("[TB] stretch 20 cycles");
    resp = '1;
    TxData = 8'h00;
    applyStimulus(7'h30, 1'b0, 8'd1);
    @(negedge CLK);
    checkOutput("st_nack_cleared", 32'(Nack), 32'd0);
    waitRise("st", 9);
    n = 0;
    while (SCL && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("st_scl_fall_timeout", 32'(n < 100), 32'd1);
    scl_high = 0;
    repeat (20) begin
      @(negedge CLK);
      if (SCL) scl_high++;
    end
    checkOutput("st_scl_high_during_wait", 32'(scl_high), 32'd0);
    checkOutput("st_txready_during_wait", 32'(tx_ready_total - tx_base), 32'd0);
    checkOutput("st_busy_during_wait", 32'(Busy), 32'd1);
    @(posedge CLK); #1;
    TxData = 8'h5A;
    TxValid = 1'b1;
    @(posedge CLK); #1;
    TxData = 8'hFF;
    TxValid = 1'b0;
    waitDone("st");
    checkOutput("st_data_bits", 32'(capBits(9, 8)), 32'h5A);
    checkOutput("st_txready_cnt", 32'(tx_ready_total - tx_base), 32'd1);

    $display("[TB] Start while busy, NBytes=0");
    resp = '1;
    applyStimulus(7'h4B, 1'b0, 8'd0);
    repeat (10) @(posedge CLK);
    #1;
    Addr = 7'h7F;
    RW = 1'b1;
    NBytes = 8'd5;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    waitDone("bz");
    checkOutput("bz_addr_bits", 32'(capBits(0, 7)), 32'h4B);
    checkOutput("bz_rw_bit", 32'(cap[7]), 32'd0);
    checkOutput("bz_cells", 32'(rise_total - rise_base), 32'd10);
    checkOutput("bz_txready_cnt", 32'(tx_ready_total - tx_base), 32'd0);
    checkOutput("bz_rxvalid_cnt", 32'(rx_valid_total - rx_base), 32'd0);
    repeat (60) @(negedge CLK);
    checkOutput("bz_idle_busy", 32'(Busy), 32'd0);
    checkOutput("bz_done_cnt", 32'(done_total - done_base), 32'd1);
    checkOutput("bz_no_restart", 32'(rise_total - rise_base), 32'd10);

    $display("[TB] reset during data bit 3");
    resp = '1;
    TxData = 8'h00;
    TxValid = 1'b1;
    applyStimulus(7'h2A, 1'b0, 8'd1);
    waitRise("rs", 13);
    checkOutput("rs_pre_scl", 32'(SCL), 32'd1);
    checkOutput("rs_pre_sda_oe", 32'(SDA_oe), 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    checkOutput("rs_scl", 32'(SCL), 32'd1);
    checkOutput("rs_sda_oe", 32'(SDA_oe), 32'd0);
    checkOutput("rs_busy", 32'(Busy), 32'd0);
    checkOutput("rs_txready", 32'(TxReady), 32'd0);
    checkOutput("rs_rxdata", 32'(RxData), 32'h00);
    repeat (3) @(negedge CLK);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    TxValid = 1'b0;
    repeat (50) @(negedge CLK);
    checkOutput("rs_no_done", 32'(done_total - done_base), 32'd0);
    checkOutput("rs_busy_after", 32'(Busy), 32'd0);

    checkOutput("pulse_overlap", 32'(overlap_total), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_address_uc.md
I2C_MASTER_ADDRESS_UC -- requirements
Module: i2c_master_address_uc

Interface
REQ-001 SHALL have parameter ADDRESSLENGTH, default 7: number of address bits sent before the R/W bit.
REQ-002 SHALL have parameter CLKDIV, default 4: CLK cycles per SCL quarter-phase, with a minimum of 1.
REQ-003 CLK  input  1  single system clock; all logic on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 Start  input  1  request transaction; sampled only in IDLE.
REQ-006 Addr  input  ADDRESSLENGTH  target address, latched on accept.
REQ-007 RW  input  1  0 = master write (slave stores), 1 = master read (slave drives data); latched on accept.
REQ-008 NBytes  input  8  data bytes in transaction; 0 = address phase only; latched on accept.
REQ-009 TxData  input  8  byte to send in write mode.
REQ-010 TxValid  input  1  TxData valid.
REQ-011 TxReady  output  1  one-cycle pulse: TxData consumed this cycle.
REQ-012 RxData  output  8  last byte received in read mode.
REQ-013 RxValid  output  1  one-cycle pulse: RxData updated.
REQ-014 Busy  output  1  transaction in progress.
REQ-015 Done  output  1  one-cycle pulse at end of STOP.
REQ-016 Nack  output  1  sticky: last transaction aborted on NACK; cleared on next accepted Start.
REQ-017 SCL  output  1  bus clock, driven push-pull.
REQ-018 SDA_in  input  1  sampled bus data line.
REQ-019 SDA_oe  output  1  1 = pull SDA low; 0 = release (line reads high).

Function
REQ-020 SHALL use states IDLE, START, ADDR, RWBIT, AACK, DATA, DACK, STOP.
REQ-021 Each bit cell SHALL be 4 quarter-phases of CLKDIV cycles: q0 SCL low and SDA updated, q1/q2 SCL high, q3 SCL low; SDA_in SHALL be sampled on the last cycle of q1.
REQ-022 IDLE: SCL=1, SDA_oe=0; Start=1 SHALL latch Addr/RW/NBytes, clear Nack, set Busy, and enter START next cycle.
REQ-023 Start while Busy=1 SHALL be ignored.
REQ-024 START: SDA pulled low while SCL high for one quarter, then SCL low, then ADDR.
REQ-025 ADDR: ADDRESSLENGTH bits sent LSB first (Addr[0] first); RWBIT then sends the latched RW.
REQ-026 AACK: SDA released; sampled 1 = ACK (positive-ack convention of the slave unit); sampled 0 SHALL set Nack and go to STOP.
REQ-027 After ACK with NBytes=0 SHALL go to STOP; otherwise SHALL go to DATA with the byte counter set to NBytes.
REQ-028 DATA write: at q0 of bit 0, TxValid=0 SHALL hold SCL low (stretch) until TxValid=1; on acceptance TxReady pulses for one cycle and the byte is sent LSB first.
REQ-029 DACK write: SDA released; sample 1 = continue; sample 0 SHALL set Nack and go to STOP; after the last byte SHALL go to STOP.
REQ-030 DATA read: SDA released, 8 bits sampled into RxData[0..7] in that order; RxValid pulses one cycle after the 8th sample.
REQ-031 DACK read: master SHALL drive 1 (SDA_oe=0) for every byte but the last and 0 (SDA_oe=1) after the last byte, then STOP.
REQ-032 STOP: SDA low with SCL low, then SCL high, then SDA released while SCL high; Done pulses, Busy clears, and the block returns to IDLE.
REQ-033 The byte counter SHALL decrement after each DACK and SHALL never wrap below 0.
REQ-034 TxReady, RxValid and Done SHALL never be asserted simultaneously.

Reset
REQ-035 RST_N=0 SHALL immediately force: state IDLE, SCL=1, SDA_oe=0, Busy=0, Done=0, Nack=0, TxReady=0, RxValid=0, RxData=8'h00, and all counters to 0, including mid-transaction.
REQ-036 After RST_N deasserts, the first Start SHALL be accepted no earlier than the next rising CLK edge.

Verification (ADDRESSLENGTH=7, CLKDIV=2)
REQ-037 Write: Addr=7'h2A, RW=0, NBytes=1, TxData=8'hA5, slave ACKs -> SDA bits 0,1,0,1,0,1,0, RW bit 0, data bits 1,0,1,0,0,1,0,1, one TxReady pulse, STOP, Done=1, Nack=0.
REQ-038 Read: Addr=7'h11, RW=1, NBytes=2, slave drives 8'h3C then 8'hC3 -> RxValid twice with RxData 8'h3C then 8'hC3, master ack 1 then 0, then STOP.
REQ-039 Address NACK: AACK samples 0 -> Nack=1, no TxReady, STOP, Done pulse, Busy=0.
REQ-040 Stretch: TxValid held low 20 cycles at the byte boundary -> SCL stays 0 for the whole wait, then the byte is sent unchanged.
REQ-041 RST_N pulsed low during bit 3 of a data byte -> same cycle SCL=1, SDA_oe=0, Busy=0, and no Done pulse.
REQ-042 Start asserted while Busy=1 -> ignored; NBytes=0 -> address + ACK then STOP with no TxReady or RxValid.
